grant_index_decoder: RTL

Registered index-to-one-hot grant issuer: the inverse of the controller's LSB priority encoder. It accepts a binary requester index over a valid/ready handshake and drives a one-hot grant vector. It holds the grant until the requester signals completion or an optional hold timeout expires, then inserts a one-cycle release bubble. It sits between the arbitration encoder and the per-requester grant lines (e.g. bank/queue select) in the DDR command path.

---
 rtl/grant_index_decoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/grant_index_decoder.sv
// grant_index_decoder: registered index-to-one-hot grant issuer with a one-cycle release bubble.
// Define GRANT_TIMEOUT_EN to force release after hold_max GRANT cycles.
module grant_index_decoder #(
   parameter int unsigned vector_length = 8,
   parameter int unsigned index_length  = $clog2(vector_length),
   parameter int unsigned hold_max      = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     idx_valid,
   input  logic [index_length-1:0]  idx,
   output logic                     idx_ready,
   output logic [vector_length-1:0] grant,
   output logic [index_length-1:0]  grant_idx,
   output logic                     grant_valid,
   input  logic                     grant_done,
   output logic                     idx_err,
   output logic                     timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

   localparam int unsigned              CNT_W   = $clog2(hold_max + 1);
   localparam logic [index_length:0]    VEC_LEN = (index_length + 1)'(vector_length);
   localparam logic [vector_length-1:0] ONE     = vector_length'(1);

   state_e                   state_q;
   logic [vector_length-1:0] grant_q;
   logic [index_length-1:0]  grant_idx_q;
   logic                     grant_valid_q;
   logic                     idx_err_q;
   logic                     timeout_q;
   logic                     in_range;
   logic                     expire;

   assign in_range = ({1'b0, idx} < VEC_LEN);

`ifdef GRANT_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q;

   assign expire = (hold_cnt_q == CNT_W'(hold_max - 1));

   // Saturating: the counter parks at its maximum rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         hold_cnt_q <= '0;
      end else if (state_q == GRANT && hold_cnt_q != '1) begin
         hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end
   end
`else
   logic [CNT_W-1:0] unused_hold_width;

   assign unused_hold_width = '0;
   assign expire            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         idx_err_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         idx_err_q <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (idx_valid) begin
                  if (in_range) begin
                     grant_q       <= ONE << idx;
                     grant_idx_q   <= idx;
                     grant_valid_q <= 1'b1;
                     state_q       <= GRANT;
                  end else begin
                     idx_err_q <= 1'b1;
                  end
               end
            end
            GRANT: begin
               // A completion on the expiry cycle takes precedence; no timeout pulse then.
               if (grant_done || expire) begin
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  timeout_q     <= ~grant_done;
                  state_q       <= RELEASE;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idx_ready   = (state_q == IDLE);
   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign idx_err     = idx_err_q;
   assign timeout     = timeout_q;

endmodule
